// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester L2-to-memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  localparam logic REQ_D = 1'b0;
  localparam logic REQ_I = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus of mem_arbiter; slave is the arbiter's view.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [1:0]          req_read;
  logic [1:0]          req_write;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0]   req_rdata;
  logic [1:0]          req_ready;
  logic                mem_read;
  logic                mem_write;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_ready;

  modport slave (
    input  req_read, req_write, req_addr, req_wdata, mem_rdata, mem_ready,
    output req_rdata, req_ready, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_read, req_write, req_addr, req_wdata, mem_rdata, mem_ready,
    input  req_rdata, req_ready, mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection: a lone requester always wins; on a tie ptr names the favoured side.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       grant
);

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    grant = REQ_D;
    if (req[REQ_I] && (!req[REQ_D] || ptr == REQ_I)) grant = REQ_I;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates D-side and I-side L2 ports onto one memory port, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin on ties; otherwise D-side has fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
)(
  input logic          clk,
  input logic          n_reset,
  mem_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic              grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        ready_q, ready_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;

  logic [1:0] req_any;
  logic       ptr;
  logic       pick_grant;

  assign req_any = bus.req_read | bus.req_write;

  mem_arb_pick u_pick (
    .req   (req_any),
    .ptr   (ptr),
    .grant (pick_grant)
  );

`ifdef MEM_ARB_RR_EN
  logic ptr_q, ptr_d;

  // After each grant the other requester becomes favoured for the next tie.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && |req_any) ptr_d = ~pick_grant;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) ptr_q <= REQ_D;
    else          ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = REQ_D;
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    grant_d     = grant_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ready_d     = '0;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    unique case (state_q)
      IDLE: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        if (|req_any) begin
          state_d     = BUSY;
          grant_d     = pick_grant;
          addr_d      = pick_grant ? bus.req_addr[ADDR_W +: ADDR_W]  : bus.req_addr[0 +: ADDR_W];
          wdata_d     = pick_grant ? bus.req_wdata[DATA_W +: DATA_W] : bus.req_wdata[0 +: DATA_W];
          // Read and write together is a write-back.
          op_d        = bus.req_write[pick_grant] ? OP_WRITE : OP_READ;
          mem_write_d = bus.req_write[pick_grant];
          mem_read_d  = !bus.req_write[pick_grant];
        end
      end
      BUSY: begin
        if (bus.mem_ready) begin
          state_d          = DONE;
          mem_read_d       = 1'b0;
          mem_write_d      = 1'b0;
          ready_d[grant_q] = 1'b1;
          if (op_q == OP_READ) rdata_d = bus.mem_rdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      op_q        <= OP_READ;
      grant_q     <= REQ_D;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ready_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign bus.req_rdata = rdata_q;
  assign bus.req_ready = ready_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule
